// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave register bank: word 0 is a read-only ID, words 1..NUM_REGS-1 are read/write.
// Define AXIL_REGFILE_CNT_EN to map a read-only free-running cycle counter at word index NUM_REGS.
module axil_regfile_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                STRB_W    = DATA_W / 8,
    parameter int                NUM_REGS  = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [DATA_W-1:0] ID_VALUE  = 32'hA5A5_0001
) (
    input  logic                       axil_aclk,
    input  logic                       axil_aresetn,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [ADDR_W-1:0]          s_axil_awaddr,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    input  logic [DATA_W-1:0]          s_axil_wdata,
    input  logic [STRB_W-1:0]          s_axil_wstrb,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    output logic [1:0]                 s_axil_bresp,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    input  logic [ADDR_W-1:0]          s_axil_araddr,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic [DATA_W-1:0]          s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXIL_REGFILE_CNT_EN
    localparam int NUM_SLOTS = NUM_REGS + 1;
`else
    localparam int NUM_SLOTS = NUM_REGS;
`endif
    localparam int                IDX_W = $clog2(NUM_SLOTS);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_SLOTS * 4);

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;

    w_state_t          w_state;
    logic [DATA_W-1:0] words [NUM_REGS];
    logic [IDX_W-1:0]  aw_idx;
    logic              aw_ok;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;

    // Offsets below BASE_ADDR wrap to large values and fall out of range naturally.
    logic [ADDR_W-1:0] aw_off, ar_off;
    logic [IDX_W-1:0]  aw_dec_idx, ar_dec_idx;
    logic              aw_dec_ok, ar_dec_in;

    assign aw_off     = s_axil_awaddr - BASE_ADDR;
    assign ar_off     = s_axil_araddr - BASE_ADDR;
    assign aw_dec_idx = aw_off[IDX_W+1:2];
    assign ar_dec_idx = ar_off[IDX_W+1:2];
    assign ar_dec_in  = (ar_off < LIMIT);
    assign aw_dec_ok  = (aw_off < LIMIT) && (aw_dec_idx != '0) && (int'(aw_dec_idx) < NUM_REGS);

`ifdef AXIL_REGFILE_CNT_EN
    logic [31:0] cnt;

    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) cnt <= '0;
        else               cnt <= cnt + 32'd1;
    end
`endif

    logic [DATA_W-1:0] rd_word;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ar_dec_idx == IDX_W'(i)) rd_word = words[i];
`ifdef AXIL_REGFILE_CNT_EN
        if (ar_dec_idx == IDX_W'(NUM_REGS)) rd_word = cnt;
`endif
        if (!ar_dec_in) rd_word = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            w_state        <= W_IDLE;
            s_axil_awready <= 1'b1;
            s_axil_wready  <= 1'b1;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
            aw_idx         <= '0;
            aw_ok          <= 1'b0;
            w_data         <= '0;
            w_strb         <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_axil_awvalid && s_axil_awready) begin
                        aw_idx         <= aw_dec_idx;
                        aw_ok          <= aw_dec_ok;
                        s_axil_awready <= 1'b0;
                    end
                    if (s_axil_wvalid && s_axil_wready) begin
                        w_data        <= s_axil_wdata;
                        w_strb        <= s_axil_wstrb;
                        s_axil_wready <= 1'b0;
                    end
                    // A dropped ready means that channel is already held.
                    if ((!s_axil_awready || s_axil_awvalid) && (!s_axil_wready || s_axil_wvalid))
                        w_state <= W_COMMIT;
                end
                W_COMMIT: begin
                    s_axil_bvalid <= 1'b1;
                    s_axil_bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
                    w_state       <= W_RESP;
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        s_axil_bvalid  <= 1'b0;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                        w_state        <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the register bank is reset so exported words are defined right after reset.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++)
                words[i] <= (i == 0) ? ID_VALUE : '0;
        end else if (w_state == W_COMMIT && aw_ok) begin
            for (int i = 1; i < NUM_REGS; i++)
                if (aw_idx == IDX_W'(i))
                    for (int k = 0; k < STRB_W; k++)
                        if (w_strb[k]) words[i][k*8 +: 8] <= w_data[k*8 +: 8];
        end
    end

    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            s_axil_arready <= 1'b1;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            s_axil_rresp   <= RESP_OKAY;
        end else if (s_axil_arvalid && s_axil_arready) begin
            s_axil_rdata   <= rd_word;
            s_axil_rresp   <= ar_dec_in ? RESP_OKAY : RESP_SLVERR;
            s_axil_rvalid  <= 1'b1;
            s_axil_arready <= 1'b0;
        end else if (s_axil_rvalid && s_axil_rready) begin
            s_axil_rvalid  <= 1'b0;
            s_axil_arready <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DATA_W +: DATA_W] = words[g];
    end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Self-checking bench for axil_regfile_slave: a reference register model feeds scoreboard queues of
// expected B and R responses that are popped and compared as the DUT returns them.
module tb_axil_regfile_slave;

    localparam int          NUM_REGS = 8;
    localparam logic [31:0] ID_VALUE = 32'hA5A5_0001;
    localparam int          BOUND    = 50;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     awvalid, awready, wvalid, wready, bvalid, bready;
    logic                     arvalid, arready, rvalid, rready;
    logic [31:0]              awaddr, wdata, araddr, rdata;
    logic [3:0]               wstrb;
    logic [1:0]               bresp, rresp;
    logic [NUM_REGS*32-1:0]   regs_flat;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [NUM_REGS];
    rd_exp_t     exp_r [$];
    logic [1:0]  exp_b [$];

    axil_regfile_slave #(.NUM_REGS(NUM_REGS)) dut (
        .axil_aclk      (clk),
        .axil_aresetn   (rst_n),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_awaddr  (awaddr),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_bresp   (bresp),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_araddr  (araddr),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .regs_o         (regs_flat)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void reset_model();
        model[0] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) model[i] = '0;
        exp_r.delete();
        exp_b.delete();
    endfunction

    function automatic rd_exp_t model_read(input logic [31:0] addr);
        rd_exp_t e;
        e.data = '0;
        e.resp = 2'b10;
        if (addr < 32'(NUM_REGS * 4)) begin
            e.data = model[int'(addr >> 2)];
            e.resp = 2'b00;
        end
        return e;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx;
        if (addr >= 32'(NUM_REGS * 4)) return 2'b10;
        idx = int'(addr >> 2);
        if (idx == 0) return 2'b10;
        for (int k = 0; k < 4; k++)
            if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
        return 2'b00;
    endfunction

    function automatic logic [NUM_REGS*32-1:0] flat_model();
        logic [NUM_REGS*32-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    // ---------------- channel drivers (called on a falling edge) ----------------
    task automatic send_aw(input logic [31:0] addr);
        int t = 0;
        awvalid = 1'b1;
        awaddr  = addr;
        while (!awready && t < BOUND) begin @(negedge clk); t++; end
        if (t == BOUND) begin n_cmp++; n_bad++; $display("FAIL aw_timeout: awready stayed 0 for %0d cycles", BOUND); end
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int t = 0;
        wvalid = 1'b1;
        wdata  = data;
        wstrb  = strb;
        while (!wready && t < BOUND) begin @(negedge clk); t++; end
        if (t == BOUND) begin n_cmp++; n_bad++; $display("FAIL w_timeout: wready stayed 0 for %0d cycles", BOUND); end
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr);
        int t = 0;
        arvalid = 1'b1;
        araddr  = addr;
        while (!arready && t < BOUND) begin @(negedge clk); t++; end
        if (t == BOUND) begin n_cmp++; n_bad++; $display("FAIL ar_timeout: arready stayed 0 for %0d cycles", BOUND); end
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp);
        int t = 0;
        bready = 1'b1;
        while (!bvalid && t < BOUND) begin @(negedge clk); t++; end
        if (t == BOUND) begin n_cmp++; n_bad++; $display("FAIL b_timeout: bvalid stayed 0 for %0d cycles", BOUND); end
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic get_r(output rd_exp_t got);
        int t = 0;
        rready = 1'b1;
        while (!rvalid && t < BOUND) begin @(negedge clk); t++; end
        if (t == BOUND) begin n_cmp++; n_bad++; $display("FAIL r_timeout: rvalid stayed 0 for %0d cycles", BOUND); end
        got.data = rdata;
        got.resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int gap, output logic [1:0] resp);
        exp_b.push_back(model_write(addr, data, strb));
        if (gap == 0) begin
            fork
                send_aw(addr);
                send_w(data, strb);
            join
        end else begin
            send_aw(addr);
            repeat (gap) @(negedge clk);
            send_w(data, strb);
        end
        get_b(resp);
    endtask

    task automatic do_read(input logic [31:0] addr, output rd_exp_t got);
        exp_r.push_back(model_read(addr));
        send_ar(addr);
        get_r(got);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        {awvalid, wvalid, arvalid, bready, rready} = '0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        reset_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b111_00_0000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want %b", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 9'b111_00_0000);
        end
        n_cmp++;
        if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
        n_cmp++;
        if (regs_flat !== flat_model()) begin n_bad++; $display("FAIL reset_regs: got %h want %h", regs_flat, flat_model()); end
    endtask

    task automatic test_read_basic();
        rd_exp_t got, e;
        logic [31:0] addrs [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h7;
        for (int i = 0; i < 3; i++) begin
            exp_r.push_back(model_read(addrs[i]));
            send_ar(addrs[i]);
            n_cmp++;
            if (rvalid !== 1'b1 || arready !== 1'b0) begin
                n_bad++;
                $display("FAIL rd_latency: rvalid=%b arready=%b want 1 0", rvalid, arready);
            end
            get_r(got);
            e = exp_r.pop_front();
            n_cmp++;
            if (got !== e) begin n_bad++; $display("FAIL rd_basic[%0d]: got %h/%b want %h/%b", i, got.data, got.resp, e.data, e.resp); end
            n_cmp++;
            if (arready !== 1'b1) begin n_bad++; $display("FAIL rd_arready_back: got %b want 1", arready); end
        end
    endtask

    task automatic test_write_latency();
        logic [1:0] r, eb;
        rd_exp_t got, e;
        exp_b.push_back(model_write(32'h8, 32'hDEAD_BEEF, 4'hF));
        send_aw(32'h8);
        @(negedge clk);
        send_w(32'hDEAD_BEEF, 4'hF);
        n_cmp++;
        if (bvalid !== 1'b0) begin n_bad++; $display("FAIL wr_bvalid_early: got %b want 0", bvalid); end
        @(negedge clk);
        n_cmp++;
        if (bvalid !== 1'b1) begin n_bad++; $display("FAIL wr_bvalid_latency: got %b want 1", bvalid); end
        get_b(r);
        eb = exp_b.pop_front();
        n_cmp++;
        if (r !== eb) begin n_bad++; $display("FAIL wr_bresp: got %b want %b", r, eb); end
        n_cmp++;
        if (regs_flat[2*32 +: 32] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_word2: got %h want deadbeef", regs_flat[2*32 +: 32]); end
        do_read(32'h8, got);
        e = exp_r.pop_front();
        n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL wr_readback: got %h/%b want %h/%b", got.data, got.resp, e.data, e.resp); end
    endtask

    task automatic test_wstrb();
        logic [1:0] r, eb;
        logic [31:0] dat [3];
        logic [3:0]  stb [3];
        dat[0] = 32'h1122_3344; stb[0] = 4'hF;
        dat[1] = 32'hFFFF_FFFF; stb[1] = 4'b0101;
        dat[2] = 32'hFFFF_0000; stb[2] = 4'h0;
        for (int i = 0; i < 3; i++) begin
            do_write(32'h4, dat[i], stb[i], i, r);
            eb = exp_b.pop_front();
            n_cmp++;
            if (r !== eb) begin n_bad++; $display("FAIL strb_bresp[%0d]: got %b want %b", i, r, eb); end
        end
        n_cmp++;
        if (regs_flat[1*32 +: 32] !== 32'h11FF_33FF) begin n_bad++; $display("FAIL strb_word1: got %h want 11ff33ff", regs_flat[1*32 +: 32]); end
    endtask

    task automatic test_errors();
        logic [1:0] r, eb;
        rd_exp_t got, e;
        logic [31:0] bad [4];
        bad[0] = 32'h0; bad[1] = 32'h40; bad[2] = 32'hFFFF_FFFC;
`ifdef AXIL_REGFILE_CNT_EN
        bad[3] = 32'h24;
`else
        bad[3] = 32'h20;
`endif
        for (int i = 0; i < 4; i++) begin
            do_write(bad[i], 32'hCAFE_F00D, 4'hF, 0, r);
            eb = exp_b.pop_front();
            n_cmp++;
            if (r !== eb) begin n_bad++; $display("FAIL err_bresp[%0d]: got %b want %b", i, r, eb); end
            if (i != 0) begin
                do_read(bad[i], got);
                e = exp_r.pop_front();
                n_cmp++;
                if (got !== e) begin n_bad++; $display("FAIL err_read[%0d]: got %h/%b want %h/%b", i, got.data, got.resp, e.data, e.resp); end
            end
        end
        n_cmp++;
        if (regs_flat !== flat_model()) begin n_bad++; $display("FAIL err_regs: got %h want %h", regs_flat, flat_model()); end
    endtask

    task automatic test_bready_stall();
        logic [1:0] r, eb;
        int t = 0;
        exp_b.push_back(model_write(32'h0, 32'h1234_5678, 4'hF));
        fork
            send_aw(32'h0);
            send_w(32'h1234_5678, 4'hF);
        join
        while (!bvalid && t < BOUND) begin @(negedge clk); t++; end
        if (t == BOUND) begin n_cmp++; n_bad++; $display("FAIL stall_timeout: bvalid never rose"); end
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({bvalid, bresp, awready, wready} !== 5'b1_10_00) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got %b want 11000", c, {bvalid, bresp, awready, wready});
            end
            @(negedge clk);
        end
        get_b(r);
        eb = exp_b.pop_front();
        n_cmp++;
        if (r !== eb) begin n_bad++; $display("FAIL stall_bresp: got %b want %b", r, eb); end
        n_cmp++;
        if ({awready, wready, bvalid} !== 3'b110) begin n_bad++; $display("FAIL stall_release: got %b want 110", {awready, wready, bvalid}); end
    endtask

    task automatic test_same_cycle();
        logic [1:0] r, eb;
        rd_exp_t got, e;
        do_write(32'hC, 32'h5, 4'hF, 0, r);
        eb = exp_b.pop_front();
        n_cmp++;
        if (r !== eb) begin n_bad++; $display("FAIL same_pre_bresp: got %b want %b", r, eb); end
        exp_r.push_back(model_read(32'hC));
        exp_b.push_back(model_write(32'hC, 32'h7, 4'hF));
        fork
            send_aw(32'hC);
            send_w(32'h7, 4'hF);
            send_ar(32'hC);
        join
        get_r(got);
        e = exp_r.pop_front();
        n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL same_rdata: got %h/%b want %h/%b", got.data, got.resp, e.data, e.resp); end
        get_b(r);
        eb = exp_b.pop_front();
        n_cmp++;
        if (r !== eb) begin n_bad++; $display("FAIL same_bresp: got %b want %b", r, eb); end
        do_read(32'hC, got);
        e = exp_r.pop_front();
        n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL same_after: got %h/%b want %h/%b", got.data, got.resp, e.data, e.resp); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] r, eb;
        rd_exp_t got, e;
        logic [31:0] addr;
        int a;
        for (int i = 0; i < 16; i++) begin
            a = int'($urandom_range(0, 9));
            addr = (a < NUM_REGS) ? 32'(a * 4) + 32'($urandom_range(0, 3)) : 32'h100;
            if ($urandom_range(0, 1) == 1) begin
                do_write(addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), r);
                eb = exp_b.pop_front();
                n_cmp++;
                if (r !== eb) begin n_bad++; $display("FAIL b2b_bresp[%0d]: addr %h got %b want %b", i, addr, r, eb); end
            end else begin
                do_read(addr, got);
                e = exp_r.pop_front();
                n_cmp++;
                if (got !== e) begin n_bad++; $display("FAIL b2b_read[%0d]: addr %h got %h/%b want %h/%b", i, addr, got.data, got.resp, e.data, e.resp); end
            end
        end
        n_cmp++;
        if (regs_flat !== flat_model()) begin n_bad++; $display("FAIL b2b_regs: got %h want %h", regs_flat, flat_model()); end
    endtask

`ifdef AXIL_REGFILE_CNT_EN
    task automatic test_counter();
        rd_exp_t g1, g2;
        logic [1:0] r, eb;
        logic [31:0] diff;
        send_ar(32'h20);
        get_r(g1);
        repeat (5) @(negedge clk);
        send_ar(32'h20);
        get_r(g2);
        diff = g2.data - g1.data;
        n_cmp++;
        if (diff !== 32'd7 || g1.resp !== 2'b00 || g2.resp !== 2'b00) begin
            n_bad++;
            $display("FAIL cnt_delta: got %0d resp %b/%b want 7 resp 00/00", diff, g1.resp, g2.resp);
        end
        do_write(32'h20, 32'h0, 4'hF, 0, r);
        eb = exp_b.pop_front();
        n_cmp++;
        if (r !== eb) begin n_bad++; $display("FAIL cnt_write: got %b want %b", r, eb); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [1:0] r, eb;
        rd_exp_t got, e;
        do_write(32'h14, 32'h0BAD_CAFE, 4'hF, 0, r);
        eb = exp_b.pop_front();
        n_cmp++;
        if (r !== eb) begin n_bad++; $display("FAIL mid_pre_bresp: got %b want %b", r, eb); end
        fork
            send_aw(32'h18);
            send_w(32'h5555_AAAA, 4'hF);
            send_ar(32'h14);
        join
        n_cmp++;
        if (rvalid !== 1'b1) begin n_bad++; $display("FAIL mid_rvalid_pending: got %b want 1", rvalid); end
        #2 rst_n = 1'b0;
        #1;
        reset_model();
        n_cmp++;
        if ({rvalid, bvalid} !== 2'b00) begin n_bad++; $display("FAIL mid_async_clear: rvalid/bvalid got %b want 00", {rvalid, bvalid}); end
        n_cmp++;
        if (regs_flat !== flat_model()) begin n_bad++; $display("FAIL mid_regs: got %h want %h", regs_flat, flat_model()); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
            n_bad++;
            $display("FAIL mid_release: got %b want 11100", {arready, awready, wready, rvalid, bvalid});
        end
        do_read(32'h14, got);
        e = exp_r.pop_front();
        n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL mid_readback: got %h/%b want %h/%b", got.data, got.resp, e.data, e.resp); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_write_latency();
        test_wstrb();
        test_errors();
        test_bready_stall();
        test_same_cycle();
        test_back_to_back();
`ifdef AXIL_REGFILE_CNT_EN
        test_counter();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
